// File: rtl/sparse_chunk_sram_rx.sv
// rtl/sparse_chunk_sram_rx.sv - receive end of the sparse-chunk SRAM write stream
// Purpose: stores sparsemap/nonzero write beats into banked chunk memory,
//   commits chunks with their beat and nonzero counts, and serves
//   whole-chunk burst reads to the PE-side consumer.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   wr_*      : write beat stream (no backpressure), wr_err_o sticky error
//   chunk_*   : commit pulse with slot/nz count, per-slot valid bitmap
//   clr_i     : clears all valid bits
//   rd_*      : read request, miss pulse, burst beat outputs
module sparse_chunk_sram_rx #(
    parameter int BUS_SIZE       = 32,
    parameter int DAT_SIZE       = 8,
    parameter int WR_DAT_CYC_NUM = 4,
    parameter int CHUNK_NUM      = 16,
    localparam int DW  = $clog2(WR_DAT_CYC_NUM),
    localparam int CW  = $clog2(CHUNK_NUM),
    localparam int NZW = $clog2(BUS_SIZE*WR_DAT_CYC_NUM+1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_valid_i,
    input  logic [BUS_SIZE-1:0]          wr_sparsemap_i,
    input  logic [BUS_SIZE*DAT_SIZE-1:0] wr_nonzero_data_i,
    input  logic [DW-1:0]                wr_dat_count_i,
    input  logic [CW-1:0]                wr_chunk_count_i,
    output logic                         wr_err_o,
    output logic                         chunk_done_o,
    output logic [CW-1:0]                chunk_done_idx_o,
    output logic [NZW-1:0]               chunk_nz_count_o,
    output logic [CHUNK_NUM-1:0]         chunk_valid_o,
    input  logic                         clr_i,
    input  logic                         rd_req_i,
    input  logic [CW-1:0]                rd_chunk_idx_i,
    output logic                         rd_busy_o,
    output logic                         rd_miss_o,
    output logic                         rd_valid_o,
    output logic                         rd_last_o,
    output logic [DW-1:0]                rd_dat_count_o,
    output logic [BUS_SIZE-1:0]          rd_sparsemap_o,
    output logic [BUS_SIZE*DAT_SIZE-1:0] rd_nonzero_data_o,
    output logic [NZW-1:0]               rd_nz_count_o
);
    localparam int BCW  = $clog2(WR_DAT_CYC_NUM+1);
    localparam int PCW  = $clog2(BUS_SIZE+1);
    localparam int ENTW = BUS_SIZE + BUS_SIZE*DAT_SIZE;
    localparam logic [DW-1:0] LAST_DAT = DW'(WR_DAT_CYC_NUM-1);

    typedef enum logic [0:0] {RD_IDLE, RD_BURST} rd_state_e;

    function automatic logic [PCW-1:0] popcount(input logic [BUS_SIZE-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < BUS_SIZE; i++) c = c + PCW'(v[i]);
        return c;
    endfunction

    // Chunk memory and per-slot metadata; none of it is reset.
    logic [ENTW-1:0] mem_q     [CHUNK_NUM][WR_DAT_CYC_NUM];
    logic [BCW-1:0]  len_mem_q [CHUNK_NUM];
    logic [NZW-1:0]  nz_mem_q  [CHUNK_NUM];

    logic                 open_q, open_d;
    logic [CW-1:0]        cur_chunk_q, cur_chunk_d;
    logic [DW-1:0]        last_dat_q, last_dat_d;
    logic [BCW-1:0]       beats_q, beats_d;
    logic [NZW-1:0]       nz_acc_q, nz_acc_d;
    logic                 err_q, err_d;
    logic [CHUNK_NUM-1:0] valid_q, valid_d;
    logic                 done_q;
    logic [CW-1:0]        done_idx_q;
    logic [NZW-1:0]       done_nz_q;

    logic                 accept, open_start, commit;
    logic [CW-1:0]        commit_idx;
    logic [BCW-1:0]       commit_len;
    logic [NZW-1:0]       commit_nz;
    logic [PCW-1:0]       beat_nz;
    logic [DW-1:0]        exp_dat;

    always_comb begin
        open_d      = open_q;
        cur_chunk_d = cur_chunk_q;
        last_dat_d  = last_dat_q;
        beats_d     = beats_q;
        nz_acc_d    = nz_acc_q;
        err_d       = err_q;
        accept      = 1'b0;
        open_start  = 1'b0;
        commit      = 1'b0;
        commit_idx  = cur_chunk_q;
        commit_len  = beats_q;
        commit_nz   = nz_acc_q;
        beat_nz     = popcount(wr_sparsemap_i);
        exp_dat     = last_dat_q + DW'(1);
        if (wr_valid_i) begin
            if (wr_dat_count_i == '0) begin
                // Index 0 always opens a chunk; any chunk still open is committed first.
                commit      = open_q;
                accept      = 1'b1;
                open_start  = 1'b1;
                open_d      = 1'b1;
                cur_chunk_d = wr_chunk_count_i;
                last_dat_d  = '0;
                beats_d     = BCW'(1);
                nz_acc_d    = NZW'(beat_nz);
            end else if (open_q && wr_dat_count_i == exp_dat
                         && wr_chunk_count_i == cur_chunk_q) begin
                accept     = 1'b1;
                last_dat_d = wr_dat_count_i;
                beats_d    = beats_q + BCW'(1);
                nz_acc_d   = nz_acc_q + NZW'(beat_nz);
                if (wr_dat_count_i == LAST_DAT) begin
                    commit     = 1'b1;
                    commit_len = beats_d;
                    commit_nz  = nz_acc_d;
                    open_d     = 1'b0;
                end
            end else begin
                // Protocol violation: beat dropped, open chunk abandoned.
                err_d  = 1'b1;
                open_d = 1'b0;
            end
        end else if (open_q) begin
            // A gap in the stream closes a partial chunk.
            commit = 1'b1;
            open_d = 1'b0;
        end
        // Order matters: clear-all, then commit sets, then a reopen clears its slot.
        valid_d = clr_i ? '0 : valid_q;
        if (commit)     valid_d[commit_idx]       = 1'b1;
        if (open_start) valid_d[wr_chunk_count_i] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            open_q      <= 1'b0;
            cur_chunk_q <= '0;
            last_dat_q  <= '0;
            beats_q     <= '0;
            nz_acc_q    <= '0;
            err_q       <= 1'b0;
            valid_q     <= '0;
            done_q      <= 1'b0;
            done_idx_q  <= '0;
            done_nz_q   <= '0;
        end else begin
            open_q      <= open_d;
            cur_chunk_q <= cur_chunk_d;
            last_dat_q  <= last_dat_d;
            beats_q     <= beats_d;
            nz_acc_q    <= nz_acc_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            done_q      <= commit;
            if (commit) begin
                done_idx_q <= commit_idx;
                done_nz_q  <= commit_nz;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && accept)
            mem_q[wr_chunk_count_i][wr_dat_count_i] <= {wr_sparsemap_i, wr_nonzero_data_i};
        if (rst_i && commit) begin
            len_mem_q[commit_idx] <= commit_len;
            nz_mem_q[commit_idx]  <= commit_nz;
        end
    end

    rd_state_e                    rd_state_q;
    logic                         rd_miss_q, rd_valid_q, rd_last_q;
    logic [DW-1:0]                rd_dat_q;
    logic [CW-1:0]                rd_idx_q;
    logic [BCW-1:0]               rd_len_q;
    logic [BUS_SIZE-1:0]          rd_map_q;
    logic [BUS_SIZE*DAT_SIZE-1:0] rd_data_q;
    logic [NZW-1:0]               rd_nz_q;

    // Burst length is latched at request time so a concurrent rewrite of the
    // slot cannot change the burst shape.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_state_q <= RD_IDLE;
            rd_miss_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_dat_q   <= '0;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_map_q   <= '0;
            rd_data_q  <= '0;
            rd_nz_q    <= '0;
        end else begin
            rd_miss_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                    if (rd_req_i) begin
                        if (valid_q[rd_chunk_idx_i]) begin
                            rd_state_q            <= RD_BURST;
                            rd_idx_q              <= rd_chunk_idx_i;
                            rd_len_q              <= len_mem_q[rd_chunk_idx_i];
                            rd_nz_q               <= nz_mem_q[rd_chunk_idx_i];
                            rd_valid_q            <= 1'b1;
                            rd_dat_q              <= '0;
                            rd_last_q             <= (len_mem_q[rd_chunk_idx_i] == BCW'(1));
                            {rd_map_q, rd_data_q} <= mem_q[rd_chunk_idx_i][DW'(0)];
                        end else begin
                            rd_miss_q <= 1'b1;
                        end
                    end
                end
                RD_BURST: begin
                    if (rd_last_q) begin
                        rd_state_q <= RD_IDLE;
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                    end else begin
                        rd_dat_q              <= rd_dat_q + DW'(1);
                        {rd_map_q, rd_data_q} <= mem_q[rd_idx_q][rd_dat_q + DW'(1)];
                        rd_last_q             <= (BCW'(rd_dat_q) + BCW'(2) == rd_len_q);
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign wr_err_o          = err_q;
    assign chunk_done_o      = done_q;
    assign chunk_done_idx_o  = done_idx_q;
    assign chunk_nz_count_o  = done_nz_q;
    assign chunk_valid_o     = valid_q;
    assign rd_busy_o         = (rd_state_q != RD_IDLE);
    assign rd_miss_o         = rd_miss_q;
    assign rd_valid_o        = rd_valid_q;
    assign rd_last_o         = rd_last_q;
    assign rd_dat_count_o    = rd_dat_q;
    assign rd_sparsemap_o    = rd_map_q;
    assign rd_nonzero_data_o = rd_data_q;
    assign rd_nz_count_o     = rd_nz_q;
endmodule

// File: tb/tb_sparse_chunk_sram_rx.sv
// tb/tb_sparse_chunk_sram_rx.sv - randomized self-checking bench for sparse_chunk_sram_rx
module tb_sparse_chunk_sram_rx;
    localparam int BUS  = 32;
    localparam int NB   = 4;
    localparam int NC   = 16;
    localparam int DATW = BUS*8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            rst_i, wr_valid_i, clr_i, rd_req_i;
    logic [BUS-1:0]  wr_sparsemap_i;
    logic [DATW-1:0] wr_nonzero_data_i;
    logic [1:0]      wr_dat_count_i;
    logic [3:0]      wr_chunk_count_i, rd_chunk_idx_i;
    logic            wr_err_o, chunk_done_o, rd_busy_o, rd_miss_o, rd_valid_o, rd_last_o;
    logic [3:0]      chunk_done_idx_o;
    logic [7:0]      chunk_nz_count_o, rd_nz_count_o;
    logic [NC-1:0]   chunk_valid_o;
    logic [1:0]      rd_dat_count_o;
    logic [BUS-1:0]  rd_sparsemap_o;
    logic [DATW-1:0] rd_nonzero_data_o;

    sparse_chunk_sram_rx dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_valid_i(wr_valid_i), .wr_sparsemap_i(wr_sparsemap_i),
        .wr_nonzero_data_i(wr_nonzero_data_i), .wr_dat_count_i(wr_dat_count_i),
        .wr_chunk_count_i(wr_chunk_count_i), .wr_err_o(wr_err_o),
        .chunk_done_o(chunk_done_o), .chunk_done_idx_o(chunk_done_idx_o),
        .chunk_nz_count_o(chunk_nz_count_o), .chunk_valid_o(chunk_valid_o),
        .clr_i(clr_i), .rd_req_i(rd_req_i), .rd_chunk_idx_i(rd_chunk_idx_i),
        .rd_busy_o(rd_busy_o), .rd_miss_o(rd_miss_o), .rd_valid_o(rd_valid_o),
        .rd_last_o(rd_last_o), .rd_dat_count_o(rd_dat_count_o),
        .rd_sparsemap_o(rd_sparsemap_o), .rd_nonzero_data_o(rd_nonzero_data_o),
        .rd_nz_count_o(rd_nz_count_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [BUS-1:0]  map;
        logic [DATW-1:0] dat;
    } beat_t;

    typedef struct packed {
        beat_t      b;
        logic [1:0] cnt;
        logic       last;
        logic [7:0] nz;
    } rdexp_t;

    beat_t         mmem [NC][NB];
    int            mlen [NC];
    int            mnz  [NC];
    logic [NC-1:0] mv;
    bit            mopen;
    int            mslot;
    beat_t         obeats[$];
    bit            e_err, e_done, e_miss;
    int            e_idx, e_nz;
    rdexp_t        rq[$];
    bit            m_busy;
    int            bslot;

    task automatic m_commit();
        int nz;
        nz = 0;
        for (int i = 0; i < obeats.size(); i++) begin
            mmem[mslot][i] = obeats[i];
            nz += $countones(obeats[i].map);
        end
        mlen[mslot] = obeats.size();
        mnz[mslot]  = nz;
        e_done = 1'b1;
        e_idx  = mslot;
        e_nz   = nz;
        mopen  = 1'b0;
    endtask

    task automatic model_edge();
        int     cslot, oslot;
        beat_t  nb;
        rdexp_t r;
        cslot = -1;
        oslot = -1;
        if (!rst_i) begin
            mv = '0; mopen = 0; obeats.delete(); rq.delete();
            e_err = 0; e_done = 0; e_miss = 0; e_idx = 0; e_nz = 0; m_busy = 0;
            return;
        end
        e_done = 0;
        e_miss = 0;
        if (rd_req_i && !m_busy) begin
            if (mv[rd_chunk_idx_i]) begin
                bslot = rd_chunk_idx_i;
                for (int i = 0; i < mlen[bslot]; i++) begin
                    r.b    = mmem[bslot][i];
                    r.cnt  = 2'(i);
                    r.last = (i == mlen[bslot] - 1);
                    r.nz   = 8'(mnz[bslot]);
                    rq.push_back(r);
                end
            end else begin
                e_miss = 1;
            end
        end
        nb.map = wr_sparsemap_i;
        nb.dat = wr_nonzero_data_i;
        if (wr_valid_i) begin
            if (wr_dat_count_i == 0) begin
                if (mopen) begin m_commit(); cslot = e_idx; end
                mopen = 1; mslot = wr_chunk_count_i; oslot = mslot;
                obeats.delete();
                obeats.push_back(nb);
            end else if (mopen && wr_dat_count_i == obeats.size() && wr_chunk_count_i == mslot) begin
                obeats.push_back(nb);
                if (obeats.size() == NB) begin m_commit(); cslot = e_idx; end
            end else begin
                e_err = 1;
                mopen = 0;
            end
        end else if (mopen) begin
            m_commit();
            cslot = e_idx;
        end
        if (clr_i)      mv = '0;
        if (cslot >= 0) mv[cslot] = 1'b1;
        if (oslot >= 0) mv[oslot] = 1'b0;
    endtask

    task automatic check_cycle();
        rdexp_t r;
        chk("err", wr_err_o, e_err);
        chk("done", chunk_done_o, e_done);
        if (e_done) begin
            chk("done_idx", chunk_done_idx_o, e_idx);
            chk("done_nz", chunk_nz_count_o, e_nz);
        end
        chk("valid_map", chunk_valid_o, mv);
        chk("miss", rd_miss_o, e_miss);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("rd_valid", rd_valid_o, 1);
            chk("rd_last", rd_last_o, r.last);
            chk("rd_cnt", rd_dat_count_o, r.cnt);
            chk("rd_map", rd_sparsemap_o, r.b.map);
            chk("rd_data", rd_nonzero_data_o, r.b.dat);
            chk("rd_nz", rd_nz_count_o, r.nz);
            m_busy = 1;
        end else begin
            chk("rd_valid", rd_valid_o, 0);
            m_busy = 0;
        end
        chk("rd_busy", rd_busy_o, m_busy);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        check_cycle();
        rst_i = 1; wr_valid_i = 0; rd_req_i = 0; clr_i = 0;
    endtask

    task automatic set_beat(input int slot, input int idx, input logic [BUS-1:0] map);
        wr_valid_i       = 1;
        wr_chunk_count_i = 4'(slot);
        wr_dat_count_i   = 2'(idx);
        wr_sparsemap_i   = map;
        for (int k = 0; k < 8; k++) wr_nonzero_data_i[k*32 +: 32] = $urandom();
    endtask

    function automatic logic [BUS-1:0] rnd_map();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int ch_slot, ch_len, ch_pos, rslot, s, nz5;
        bit ch_active;
        rst_i = 0; wr_valid_i = 0; clr_i = 0; rd_req_i = 0;
        wr_sparsemap_i = '0; wr_nonzero_data_i = '0; wr_dat_count_i = '0;
        wr_chunk_count_i = '0; rd_chunk_idx_i = '0;
        tick();
        rst_i = 0;
        tick();
        chk("rst_done_idx", chunk_done_idx_o, 0);
        chk("rst_done_nz", chunk_nz_count_o, 0);
        chk("rst_rd_last", rd_last_o, 0);
        chk("rst_rd_cnt", rd_dat_count_o, 0);
        chk("rst_rd_map", rd_sparsemap_o, 0);
        chk("rst_rd_data", rd_nonzero_data_o, 0);
        chk("rst_rd_nz", rd_nz_count_o, 0);

        // full chunk to slot 3
        for (int i = 0; i < 4; i++) begin set_beat(3, i, 32'hFFFF0000); tick(); end
        chk("full_done", chunk_done_o, 1);
        chk("full_idx", chunk_done_idx_o, 3);
        chk("full_nz", chunk_nz_count_o, 64);
        chk("full_valid", chunk_valid_o, 16'h0008);
        tick();

        // back-to-back slots 0 and 1
        for (int s2 = 0; s2 < 2; s2++)
            for (int i = 0; i < 4; i++) begin set_beat(s2, i, $urandom()); tick(); end
        tick();
        chk("b2b_err", wr_err_o, 0);

        // partial chunk to slot 5
        set_beat(5, 0, 32'h0000_000F); tick();
        set_beat(5, 1, 32'h0000_0003); tick();
        tick();
        chk("part_done", chunk_done_o, 1);
        chk("part_idx", chunk_done_idx_o, 5);
        nz5 = 6;
        chk("part_nz", chunk_nz_count_o, nz5);

        // burst of slot 3 with an ignored request, then slot 5 right after
        rd_req_i = 1; rd_chunk_idx_i = 3; tick();
        chk("rd3_first", rd_valid_o, 1);
        chk("rd3_nz", rd_nz_count_o, 64);
        rd_req_i = 1; rd_chunk_idx_i = 0; tick();
        tick(); tick();
        chk("rd3_last", rd_last_o, 1);
        rd_req_i = 1; rd_chunk_idx_i = 5; tick();
        chk("rd_ignored_busy", rd_valid_o, 0);
        rd_req_i = 1; rd_chunk_idx_i = 5; tick();
        chk("rd5_first", rd_valid_o, 1);
        tick();
        chk("rd5_last", rd_last_o, 1);
        tick();

        // miss, then clear and miss again
        rd_req_i = 1; rd_chunk_idx_i = 9; tick();
        chk("miss9", rd_miss_o, 1);
        clr_i = 1; tick();
        rd_req_i = 1; rd_chunk_idx_i = 3; tick();
        chk("miss3_after_clr", rd_miss_o, 1);
        tick();

        // index error, then reset
        set_beat(7, 0, $urandom()); tick();
        set_beat(7, 2, $urandom()); tick();
        chk("err_set", wr_err_o, 1);
        tick();
        chk("err_no_commit", chunk_done_o, 0);
        rst_i = 0; tick();
        chk("rst_err", wr_err_o, 0);
        chk("rst_valid", chunk_valid_o, 0);

        // randomized traffic
        ch_active = 0; ch_slot = 0; ch_len = 0; ch_pos = 0;
        for (int c = 0; c < 3000; c++) begin
            rslot = -1;
            if ($urandom_range(0, 3) == 0) begin
                rd_req_i = 1;
                rd_chunk_idx_i = 4'($urandom_range(0, NC-1));
                rslot = rd_chunk_idx_i;
            end
            if ($urandom_range(0, 63) == 0) clr_i = 1;
            if ($urandom_range(0, 499) == 0) begin
                rst_i = 0;
                ch_active = 0;
            end else if (ch_active) begin
                if ($urandom_range(0, 31) == 0) begin
                    set_beat(ch_slot ^ 1, ch_pos, rnd_map());
                    ch_active = 0;
                end else begin
                    set_beat(ch_slot, ch_pos, rnd_map());
                    ch_pos++;
                    if (ch_pos == ch_len) ch_active = 0;
                end
            end else if ($urandom_range(0, 2) != 0) begin
                s = $urandom_range(0, NC-1);
                while ((m_busy && s == bslot) || s == rslot) s = (s + 1) % NC;
                ch_slot = s;
                ch_len = $urandom_range(1, NB);
                set_beat(s, 0, rnd_map());
                ch_pos = 1;
                ch_active = (ch_len > 1);
            end
            tick();
        end
        tick(); tick(); tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sparse_chunk_sram_rx.md
Name: sparse_chunk_sram_rx

Overview:
Synthesizable receive end of the sparse-chunk SRAM write stream. Each chunk arrives as a sequence of write beats carrying a sparsemap slice and a compacted nonzero-data slice. The block stores the beats in banked chunk memory, commits chunks, counts nonzeros per chunk, and serves whole-chunk burst reads to the PE-side consumer. One instance is used per IFM or filter SRAM.

Parameters:
BUS_SIZE, 32, sparsemap bits and nonzero bytes per beat
DAT_SIZE, 8, bits per data element
WR_DAT_CYC_NUM, 4, maximum beats per chunk (chunk = BUS_SIZE*WR_DAT_CYC_NUM elements)
CHUNK_NUM, 16, number of chunk slots

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low
wr_valid_i  in  1  write beat valid
wr_sparsemap_i  in  BUS_SIZE  sparsemap slice for this beat
wr_nonzero_data_i  in  BUS_SIZE*DAT_SIZE  compacted nonzero slice for this beat
wr_dat_count_i  in  $clog2(WR_DAT_CYC_NUM)  beat index within chunk
wr_chunk_count_i  in  $clog2(CHUNK_NUM)  target chunk slot
wr_err_o  out  1  sticky protocol error
chunk_done_o  out  1  one-cycle pulse when a chunk commits
chunk_done_idx_o  out  $clog2(CHUNK_NUM)  slot committed
chunk_nz_count_o  out  $clog2(BUS_SIZE*WR_DAT_CYC_NUM+1)  nonzero count of committed chunk
chunk_valid_o  out  CHUNK_NUM  per-slot committed bitmap
clr_i  in  1  clears all chunk_valid bits
rd_req_i  in  1  read request
rd_chunk_idx_i  in  $clog2(CHUNK_NUM)  slot to read
rd_busy_o  out  1  read FSM not in IDLE
rd_miss_o  out  1  one-cycle pulse: requested slot not valid
rd_valid_o  out  1  read beat valid
rd_last_o  out  1  final beat of the burst
rd_dat_count_o  out  $clog2(WR_DAT_CYC_NUM)  beat index
rd_sparsemap_o  out  BUS_SIZE  stored sparsemap slice
rd_nonzero_data_o  out  BUS_SIZE*DAT_SIZE  stored nonzero slice
rd_nz_count_o  out  $clog2(BUS_SIZE*WR_DAT_CYC_NUM+1)  nonzero count of the slot, held for the whole burst

Behaviour:
- Reset (rst_i=0 at a clk_i edge): all outputs are 0, chunk_valid is cleared, any open chunk is discarded, and the read FSM returns to IDLE. Memory contents are not cleared.
- Write side: each cycle with wr_valid_i=1 is one beat. No backpressure.
- Expected beat index is 0 when no chunk is open, otherwise previous index+1.
- A beat with index 0 opens a chunk at wr_chunk_count_i. It clears that slot's valid bit in the same edge.
- On a beat-index mismatch, or a chunk_count change mid-chunk: set wr_err_o (sticky until reset), drop the beat, and discard the open chunk.
- Each accepted beat writes mem[chunk][dat] and adds popcount(wr_sparsemap_i) to the running count.
- Commit triggers: (a) accepted beat with index WR_DAT_CYC_NUM-1; (b) beat index 0 arriving while a chunk is open, which commits the old chunk and opens the new one in the same cycle; (c) wr_valid_i=0 while a chunk is open (partial last chunk).
- On commit:
  - Store the beat count and nz count for the slot.
  - Set chunk_valid.
  - Pulse chunk_done_o the cycle after the commit edge, with idx and count.
- clr_i clears all valid bits. A commit in the same cycle wins for its own slot.
- Read FSM states: IDLE, BURST.
- IDLE with rd_req_i=1: sample rd_chunk_idx_i.
  - Slot not valid: pulse rd_miss_o next cycle, stay in IDLE.
  - Slot valid: go to BURST. The first rd_valid_o appears 1 cycle after the request (registered memory read).
- BURST emits beats 0..beat_cnt-1 on consecutive cycles, with rd_last_o on the final beat, then returns to IDLE.
- rd_req_i is ignored while rd_busy_o=1. A new request is accepted in the cycle after rd_last_o.
- A write reopening the slot under an active burst does not alter burst length or timing. Data for that slot is unspecified for the rest of the burst.
- Widths: popcount accumulates unsigned, with no overflow by construction. Beat index wraps only through the commit rules.

Test Plan:
- Reset, then full chunk to slot 3: 4 beats, idx 0..3, maps 0xFFFF0000 each → chunk_done_o 1 cycle after beat 3 with idx=3, nz=64; chunk_valid_o=0x0008.
- Continuous valid across slots 0,1 (8 beats back-to-back) → two done pulses, with slot 0's pulse occurring on the cycle after its commit; no wr_err_o.
- Partial chunk: 2 beats to slot 5, then wr_valid_i=0 → done idx=5; a later read of slot 5 gives 2 beats, rd_last_o on beat 1.
- Read of slot 3 → rd_valid_o 1 cycle after request, 4 beats with data matching what was written, rd_nz_count_o=64; a rd_req_i during the burst is ignored.
- Read of an empty slot 9 → rd_miss_o pulse, rd_valid_o stays 0. Then clr_i, and a read of slot 3 → miss.
- Beat sequence 0,2 → wr_err_o=1, no commit. Then rst_i=0 for 1 cycle → wr_err_o=0 and chunk_valid_o=0.
